alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Bit-serial sequencer that drives one 1-bit ALU slice (mov/not/add/sub/or/and, ripple carry) LSB-first over WIDTH cycles.
- Sits directly upstream of the slice and feeds it operands, select and carry-in. It also consumes the slice's out/c_out and registers them.
- Assembles a WIDTH-bit result and hands it downstream through a valid/ready handshake.
- Gives the team a multi-bit ALU from a single slice instance.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2); cycle count per operation
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  sequencer can accept an operation
- in_select  input  3  opcode: 000 mov, 001 not, 010 add, 011 sub, 100 or, 101 and
- in_a  input  WIDTH  operand A (slice r2)
- in_b  input  WIDTH  operand B (slice r3)
- slice_select  output  3  select driven to the slice
- slice_r2  output  1  current A bit
- slice_r3  output  1  current B bit
- slice_c_in  output  1  carry into the slice
- slice_out  input  1  slice result bit (combinational from slice_* outputs)
- slice_c_out  input  1  slice carry-out
- res_valid  output  1  result valid
- res_ready  input  1  downstream accepts result
- res_data  output  WIDTH  assembled result
- res_carry  output  1  final carry (add/sub only)
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, carry flop=0, op/operand/result registers=0. Outputs: res_valid=0, res_data=0, res_carry=0, in_ready=1, busy=0, all slice_* outputs=0.
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE.
- IDLE: on in_valid&in_ready at an edge, latch in_select, in_a and in_b into shift regs and clear count. Carry flop loads 1 if in_select==011 (two's-complement subtract), else 0. Go to SHIFT.
- SHIFT, per cycle:
  - slice_r2/slice_r3 are the LSBs of the A/B shift regs; slice_select is the latched op; slice_c_in is the carry flop.
  - At the edge: shift slice_out into the MSB of the result shift reg and shift A/B right by 1. Carry flop takes slice_c_out. count increments.
  - When count==WIDTH-1 at the edge, go to DONE.
- Latency: accept edge E0; exactly WIDTH SHIFT cycles; res_valid rises after edge E0+WIDTH. Result bit i is sampled in SHIFT cycle i.
- DONE:
  - res_valid=1. res_data holds the result register. res_carry is the carry flop if op ∈ {010, 011}, else 0.
  - Outputs are held stable while res_ready=0 (unbounded backpressure).
  - On res_valid&res_ready go to IDLE, and res_valid falls next cycle. The next operation can be accepted no earlier than the cycle after the return to IDLE; no skid/overlap.
- Slice outputs are 0 in IDLE and DONE.
- Carry semantics: add carry-out=1 means unsigned overflow. Sub carry-out=1 means no borrow (A≥B unsigned).
- Opcodes 110/111: sequenced normally and passed to the slice unchanged. res_data is whatever the slice returns; res_carry forced 0.
- in_valid in SHIFT/DONE is ignored (in_ready=0). Input ports are not sampled outside the accept edge.
- Reset mid-SHIFT or mid-DONE: immediate return to IDLE with all reset values. The partial result is discarded and never presented.
- Simultaneous res_ready rise and in_valid in DONE: the result handshake completes; the new op is accepted only once back in IDLE.

Test Plan (WIDTH=8, slice model attached):
- add 0x7F+0x01 -> res_data=0x80, res_carry=0, res_valid exactly 8 cycles after accept edge.
- add 0xFF+0x01 -> res_data=0x00, res_carry=1. Then sub 0x05-0x03 -> res_data=0x02, res_carry=1 (slice_c_in=1 in the first SHIFT cycle).
- sub 0x03-0x05 -> res_data=0xFE, res_carry=0. and 0xF0&0x3C -> 0x30, res_carry=0. or 0xF0|0x0C -> 0xFC. not 0xA5 -> 0x5A. mov 0x96 -> 0x96.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_data/res_carry stable, in_ready=0, and a pulsed in_valid is not accepted. Raise res_ready -> IDLE next cycle.
- Reset: assert rst_n=0 in SHIFT cycle 3 of add 0x55+0x55 -> outputs reset immediately, with no res_valid. Release, then add 0x01+0x02 -> 0x03.
- Back-to-back: in_valid held high with res_ready=1 -> two ops complete, with exactly one IDLE cycle between DONE and the next accept.

Source files
------------

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving one 1-bit ALU slice LSB-first over WIDTH cycles.
// Assembles the WIDTH-bit result and hands it downstream through a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for an operation, slice inputs held at 0
// SHIFT | one slice bit per cycle, LSB first
// DONE  | result presented until res_ready
module alu_serial_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_select,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [2:0]       slice_select,
  output logic             slice_r2,
  output logic             slice_r3,
  output logic             slice_c_in,
  input  logic             slice_out,
  input  logic             slice_c_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_shift;
  logic w_done;
  logic w_last;
  logic w_arith;

  assign w_shift  = (r_state == S_SHIFT);
  assign w_done   = (r_state == S_DONE);
  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_arith  = (r_op == 3'b010) || (r_op == 3'b011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_SHIFT;
      S_SHIFT: if (w_last)    w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Carry flop is preset for subtract so the slice computes A + ~B + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_op    <= in_select;
      r_a     <= in_a;
      r_b     <= in_b;
      r_cnt   <= '0;
      r_carry <= (in_select == 3'b011);
    end else if (w_shift) begin
      r_res   <= {slice_out, r_res[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= slice_c_out;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = w_shift || w_done;
  assign slice_select = w_shift ? r_op : 3'b000;
  assign slice_r2     = w_shift & r_a[0];
  assign slice_r3     = w_shift & r_b[0];
  assign slice_c_in   = w_shift & r_carry;
  assign res_valid    = w_done;
  assign res_data     = w_done ? r_res : '0;
  assign res_carry    = w_done & w_arith & r_carry;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq: attached 1-bit slice model, directed and random
// operations checked against a word-level arithmetic reference.
module tb_alu_serial_seq;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_select = 3'b000;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       slice_select;
  logic             slice_r2, slice_r3, slice_c_in;
  logic             slice_out, slice_c_out;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select),
    .in_a(in_a), .in_b(in_b),
    .slice_select(slice_select), .slice_r2(slice_r2), .slice_r3(slice_r3),
    .slice_c_in(slice_c_in), .slice_out(slice_out), .slice_c_out(slice_c_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .busy(busy)
  );

  // 1-bit slice: 110 is xor, 111 returns 0.
  always_comb begin
    slice_out   = 1'b0;
    slice_c_out = 1'b0;
    case (slice_select)
      3'b000: slice_out = slice_r2;
      3'b001: slice_out = ~slice_r2;
      3'b010: begin
        slice_out   = slice_r2 ^ slice_r3 ^ slice_c_in;
        slice_c_out = (slice_r2 & slice_r3) | (slice_r2 & slice_c_in) | (slice_r3 & slice_c_in);
      end
      3'b011: begin
        slice_out   = slice_r2 ^ ~slice_r3 ^ slice_c_in;
        slice_c_out = (slice_r2 & ~slice_r3) | (slice_r2 & slice_c_in) | (~slice_r3 & slice_c_in);
      end
      3'b100: slice_out = slice_r2 | slice_r3;
      3'b101: slice_out = slice_r2 & slice_r3;
      3'b110: slice_out = slice_r2 ^ slice_r3;
      default: slice_out = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level reference.
  task automatic model(input logic [2:0] sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] d, output logic c);
    logic [WIDTH:0] s;
    s = '0;
    c = 1'b0;
    case (sel)
      3'd0: d = a;
      3'd1: d = ~a;
      3'd2: begin s = {1'b0, a} + {1'b0, b}; d = s[WIDTH-1:0]; c = s[WIDTH]; end
      3'd3: begin d = a - b; c = (a >= b); end
      3'd4: d = a | b;
      3'd5: d = a & b;
      3'd6: d = a ^ b;
      default: d = '0;
    endcase
  endtask

  // Called at posedge+1 in IDLE. Leaves the DUT in DONE unless do_hs is set.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit do_hs);
    logic [WIDTH-1:0] ed;
    logic             ec;
    int               n;
    model(sel, a, b, ed, ec);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_select = sel; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_select = $urandom; in_a = $urandom; in_b = $urandom;
    chk({tag, "_first_c_in"}, 32'(slice_c_in), 32'(sel == 3'b011));
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (res_valid) break;
    end
    chk({tag, "_latency"}, 32'(n), 32'(WIDTH));
    chk({tag, "_data"}, 32'(res_data), 32'(ed));
    chk({tag, "_carry"}, 32'(res_carry), 32'(ec));
    chk({tag, "_slice_idle"}, 32'({slice_select, slice_r2, slice_r3, slice_c_in}), 32'd0);
    if (do_hs) begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk({tag, "_hs_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] held_d;
    logic             held_c;
    int               n;

    #1;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_slice", 32'({slice_select, slice_r2, slice_r3, slice_c_in}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add7f", 3'b010, 8'h7F, 8'h01, 1'b1);
    run_op("addff", 3'b010, 8'hFF, 8'h01, 1'b1);
    run_op("sub53", 3'b011, 8'h05, 8'h03, 1'b1);
    run_op("sub35", 3'b011, 8'h03, 8'h05, 1'b1);
    run_op("and",   3'b101, 8'hF0, 8'h3C, 1'b1);
    run_op("or",    3'b100, 8'hF0, 8'h0C, 1'b1);
    run_op("not",   3'b001, 8'hA5, 8'h00, 1'b1);
    run_op("mov",   3'b000, 8'h96, 8'h00, 1'b1);
    run_op("op110", 3'b110, 8'hC3, 8'h5A, 1'b1);
    run_op("op111", 3'b111, 8'hFF, 8'hFF, 1'b1);

    // Backpressure with an ignored in_valid pulse.
    run_op("bp", 3'b010, 8'hC8, 8'h64, 1'b0);
    held_d = res_data;
    held_c = res_carry;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin in_valid = 1'b1; in_select = 3'b000; in_a = 8'h11; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_data", 32'(res_data), 32'(held_d));
      chk("bp_carry", 32'(res_carry), 32'(held_c));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_pulse_ignored", 32'(busy), 32'd0);

    // Reset in SHIFT cycle 3.
    in_valid = 1'b1; in_select = 3'b010; in_a = 8'h55; in_b = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out", 32'({res_valid, res_carry, res_data}), 32'd0);
    chk("mid_rst_slice", 32'({slice_select, slice_r2, slice_r3, slice_c_in}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (res_valid) n++;
    end
    chk("post_rst_no_valid", 32'(n), 32'd0);
    run_op("add12", 3'b010, 8'h01, 8'h02, 1'b1);

    // Back-to-back with in_valid held and res_ready high.
    res_ready = 1'b1;
    in_valid = 1'b1; in_select = 3'b010; in_a = 8'h10; in_b = 8'h20;
    @(posedge clk); #1;
    in_select = 3'b011; in_a = 8'h40; in_b = 8'h01;
    n = 0;
    while (n < 40 && !res_valid) begin @(posedge clk); #1; n++; end
    chk("b2b_lat1", 32'(n), 32'(WIDTH));
    chk("b2b_data1", 32'(res_data), 32'h30);
    @(posedge clk); #1;
    chk("b2b_idle_gap", 32'({in_ready, busy}), 32'b10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_accept2", 32'({in_ready, busy}), 32'b01);
    n = 0;
    while (n < 40 && !res_valid) begin @(posedge clk); #1; n++; end
    chk("b2b_lat2", 32'(n), 32'(WIDTH));
    chk("b2b_data2", 32'(res_data), 32'h3F);
    chk("b2b_carry2", 32'(res_carry), 32'd1);
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("b2b_end_idle", 32'(in_ready), 32'd1);

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      logic [2:0]       rs;
      logic [WIDTH-1:0] ra, rb;
      rs = 3'($urandom_range(0, 7));
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      run_op("rnd", rs, ra, rb, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
